// File: rtl/fifo2uart_pkg.sv
// fifo2uart_pkt shared types.
// State encoding and default packet header.
package fifo2uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_CKSUM,
    S_LAST
  } state_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

endpackage

// File: rtl/fifo2uart_if.sv
// fifo2uart_pkt control, FIFO and UART bundle.
// slave = streamer side, master = surrounding logic.
interface fifo2uart_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              fs;
  logic              fd;
  logic              mode;
  logic [LEN_W-1:0]  data_len;
  logic              fifo_empty;
  logic              fifo_rxen;
  logic [DATA_W-1:0] fifo_rxd;
  logic              uart_txdv;
  logic              uart_txdr;
  logic [DATA_W-1:0] uart_txd;
  logic              err;

  modport slave (
    input  fs, mode, data_len,
    input  fifo_empty, fifo_rxd,
    input  uart_txdr,
    output fd, fifo_rxen,
    output uart_txdv, uart_txd, err
  );

  modport master (
    output fs, mode, data_len,
    output fifo_empty, fifo_rxd,
    output uart_txdr,
    input  fd, fifo_rxen,
    input  uart_txdv, uart_txd, err
  );
endinterface

// File: rtl/fifo2uart_pkt.sv
// Drains a byte FIFO (or a counting pattern) to uart_tx
// as header + payload + optional XOR checksum.
module fifo2uart_pkt
  import fifo2uart_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                LEN_W     = 8,
  parameter logic [DATA_W-1:0] HEADER    = HEADER_DEF,
  parameter bit                ADD_CKSUM = 1'b1,
  parameter int                TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  fifo2uart_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT);

  state_t            r_state;
  state_t            w_nxt;
  logic [LEN_W-1:0]  r_len;
  logic              r_mode;
  logic [LEN_W:0]    r_cnt;
  logic [DATA_W-1:0] r_ck;
  logic [DATA_W-1:0] r_data;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_err;

  logic              w_xfer;
  logic              w_last;
  logic              w_tmo_hit;
  logic              w_txdv;
  logic [DATA_W-1:0] w_txd;
  logic              w_rxen;
  logic              w_fd;

  assign w_xfer    = w_txdv & bus.uart_txdr;
  assign w_last    = (r_cnt + 1'b1) == {1'b0, r_len};
  assign w_tmo_hit = r_tmo == TMO_W'(TIMEOUT - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_txdv = 1'b0;
    w_txd  = '0;
    w_rxen = 1'b0;
    w_fd   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.fs) w_nxt = S_HEAD;
      end
      S_HEAD: begin
        w_txdv = 1'b1;
        w_txd  = HEADER;
        if (w_xfer) begin
          if (r_len != '0) w_nxt = S_FETCH;
          else if (ADD_CKSUM) w_nxt = S_CKSUM;
          else w_nxt = S_LAST;
        end
      end
      S_FETCH: begin
        if (r_mode) begin
          w_nxt = S_SEND;
        end else if (!bus.fifo_empty) begin
          w_rxen = 1'b1;
          w_nxt  = S_WAIT;
        end else if (w_tmo_hit) begin
          w_nxt = S_LAST;
        end
      end
      S_WAIT: begin
        w_nxt = S_SEND;
      end
      S_SEND: begin
        w_txdv = 1'b1;
        w_txd  = r_data;
        if (w_xfer) begin
          if (!w_last) w_nxt = S_FETCH;
          else if (ADD_CKSUM) w_nxt = S_CKSUM;
          else w_nxt = S_LAST;
        end
      end
      S_CKSUM: begin
        w_txdv = 1'b1;
        w_txd  = r_ck;
        if (w_xfer) w_nxt = S_LAST;
      end
      S_LAST: begin
        w_fd = 1'b1;
        if (!bus.fs) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Timeout counter restarts for every payload byte fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_mode <= 1'b0;
      r_cnt  <= '0;
      r_ck   <= '0;
      r_data <= '0;
      r_tmo  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.fs) begin
        r_len  <= bus.data_len;
        r_mode <= bus.mode;
        r_cnt  <= '0;
        r_ck   <= '0;
        r_tmo  <= '0;
        r_err  <= 1'b0;
      end
      if (r_state == S_FETCH) begin
        if (r_mode)               r_data <= DATA_W'(r_cnt);
        else if (!bus.fifo_empty) r_tmo  <= '0;
        else if (w_tmo_hit)       r_err  <= 1'b1;
        else                      r_tmo  <= r_tmo + 1'b1;
      end
      if (r_state == S_WAIT) r_data <= bus.fifo_rxd;
      if (r_state == S_SEND && w_xfer) begin
        r_ck  <= r_ck ^ r_data;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.fd        = w_fd;
  assign bus.fifo_rxen = w_rxen;
  assign bus.uart_txdv = w_txdv;
  assign bus.uart_txd  = w_txd;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_fifo2uart_pkt.sv
// fifo2uart_pkt bench: random and directed packets
// against a queue-based packet model.
module tb_fifo2uart_pkt;

  localparam int DW  = 8;
  localparam int LW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo2uart_if #(.DATA_W(DW), .LEN_W(LW)) bi ();
  fifo2uart_if #(.DATA_W(DW), .LEN_W(LW)) bn ();

  fifo2uart_pkt #(
    .DATA_W(DW), .LEN_W(LW), .HEADER(8'hA5),
    .ADD_CKSUM(1'b1), .TIMEOUT(TMO)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bi)
  );

  fifo2uart_pkt #(
    .DATA_W(DW), .LEN_W(LW), .HEADER(8'hA5),
    .ADD_CKSUM(1'b0), .TIMEOUT(TMO)
  ) u_nck (
    .clk(clk), .rst(rst), .bus(bn)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // FIFO model: task writes, posedge block reads
  logic [7:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rxen_tot = 0;

  // UART sink / monitor state
  logic [7:0] rx_q[$];
  logic [7:0] rxn_q[$];
  int cyc = 0;
  int viol_tot = 0;
  int last_xfer_cyc = 0;
  int fd_rise_cyc = 0;
  int rdy_mode = 0;
  logic fd_prev = 1'b0;
  logic pend = 1'b0;
  logic [7:0] pend_d = 8'h00;
  logic [7:0] dir_q[$];

  always @(posedge clk) begin
    #1;
    while (rd_ptr < rxen_tot) begin
      bi.fifo_rxd = fmem[rd_ptr % 1024];
      rd_ptr++;
    end
    bi.fifo_empty = (rd_ptr == wr_ptr);
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0;
      fd_prev = 1'b0;
      bi.uart_txdr = 1'b0;
    end else begin
      if (bi.fifo_rxen) begin
        if (bi.fifo_empty) viol_tot++;
        else rxen_tot++;
      end
      case (rdy_mode)
        0: bi.uart_txdr = 1'b1;
        1: bi.uart_txdr = (cyc % 3 == 0);
        2: bi.uart_txdr = 1'($urandom_range(0, 1));
        default: bi.uart_txdr = 1'b0;
      endcase
      if (pend && (!bi.uart_txdv || bi.uart_txd !== pend_d))
        viol_tot++;
      if (bi.uart_txdv && bi.uart_txdr) begin
        rx_q.push_back(bi.uart_txd);
        last_xfer_cyc = cyc;
        pend = 1'b0;
      end else begin
        pend = bi.uart_txdv;
        pend_d = bi.uart_txd;
      end
      if (bi.fd && !fd_prev) fd_rise_cyc = cyc;
      fd_prev = bi.fd;
    end
  end

  always @(negedge clk) begin
    if (!rst && bn.uart_txdv && bn.uart_txdr)
      rxn_q.push_back(bn.uart_txd);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    while (!bi.fd && n < 4000) begin
      tick();
      n++;
    end
  endtask

  task automatic run_pkt(input string nm, input bit md,
                         input int len, input int rm);
    logic [7:0] exp[$];
    logic [7:0] ck;
    logic [7:0] d;
    int rb, eb, vb;
    ck = 8'h00;
    rdy_mode = rm;
    rb = rx_q.size();
    eb = rxen_tot;
    vb = viol_tot;
    exp.push_back(8'hA5);
    for (int i = 0; i < len; i++) begin
      if (md) d = 8'(i);
      else if (i < dir_q.size()) d = dir_q[i];
      else d = 8'($urandom);
      if (!md) begin
        fmem[wr_ptr % 1024] = d;
        wr_ptr++;
      end
      exp.push_back(d);
      ck = ck ^ d;
    end
    exp.push_back(ck);
    bi.mode = md;
    bi.data_len = 8'(len);
    bi.fs = 1'b1;
    tick();
    chk({nm, "_err_clr"}, bi.err, 0);
    wait_fd();
    chk({nm, "_fd"}, bi.fd, 1);
    chk({nm, "_err"}, bi.err, 0);
    chk({nm, "_nbytes"}, rx_q.size() - rb, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (rb + i < rx_q.size())
        chk($sformatf("%s_b%0d", nm, i), rx_q[rb + i], exp[i]);
    chk({nm, "_rxen"}, rxen_tot - eb, md ? 0 : len);
    chk({nm, "_hs"}, viol_tot - vb, 0);
    tick();
    chk({nm, "_fd_hold"}, bi.fd, 1);
    bi.fs = 1'b0;
    tick();
    chk({nm, "_fd_drop"}, bi.fd, 0);
    tick();
  endtask

  task automatic run_nck(input string nm, input bit md,
                         input int len);
    int rb, n;
    rb = rxn_q.size();
    bn.mode = md;
    bn.data_len = 8'(len);
    bn.fs = 1'b1;
    n = 0;
    tick();
    while (!bn.fd && n < 2000) begin
      tick();
      n++;
    end
    chk({nm, "_fd"}, bn.fd, 1);
    chk({nm, "_nbytes"}, rxn_q.size() - rb, len + 1);
    if (rb < rxn_q.size())
      chk({nm, "_hdr"}, rxn_q[rb], 8'hA5);
    for (int i = 0; i < len; i++)
      if (rb + 1 + i < rxn_q.size())
        chk($sformatf("%s_b%0d", nm, i), rxn_q[rb + 1 + i], 8'(i));
    bn.fs = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, eb;
    bi.fs = 1'b0;
    bi.mode = 1'b0;
    bi.data_len = '0;
    bn.fs = 1'b0;
    bn.mode = 1'b0;
    bn.data_len = '0;
    bn.fifo_empty = 1'b1;
    bn.fifo_rxd = '0;
    bn.uart_txdr = 1'b1;
    repeat (3) tick();
    chk("rst_fd", bi.fd, 0);
    chk("rst_txdv", bi.uart_txdv, 0);
    chk("rst_rxen", bi.fifo_rxen, 0);
    chk("rst_err", bi.err, 0);
    chk("rst_txd", bi.uart_txd, 0);
    rst = 1'b0;
    tick();
    tick();

    dir_q = '{8'h11, 8'h22, 8'h33};
    run_pkt("fifo3", 1'b0, 3, 0);
    dir_q.delete();
    run_pkt("pat4", 1'b1, 4, 0);
    run_pkt("len0", 1'b0, 0, 0);
    dir_q = '{8'h5A, 8'hC3};
    run_pkt("slow2", 1'b0, 2, 1);
    dir_q.delete();

    // FIFO runs dry after the first payload byte
    rdy_mode = 0;
    rb = rx_q.size();
    eb = rxen_tot;
    fmem[wr_ptr % 1024] = 8'h3C;
    wr_ptr++;
    bi.mode = 1'b0;
    bi.data_len = 8'd4;
    bi.fs = 1'b1;
    tick();
    wait_fd();
    chk("to_fd", bi.fd, 1);
    chk("to_err", bi.err, 1);
    chk("to_nbytes", rx_q.size() - rb, 2);
    chk("to_b0", rx_q[rb], 8'hA5);
    chk("to_b1", rx_q[rb + 1], 8'h3C);
    chk("to_rxen", rxen_tot - eb, 1);
    chk("to_wait", fd_rise_cyc - last_xfer_cyc, TMO + 1);
    bi.fs = 1'b0;
    tick();
    chk("to_fd_drop", bi.fd, 0);
    chk("to_err_hold", bi.err, 1);
    tick();
    run_pkt("after_to", 1'b1, 2, 0);

    // reset while a payload byte is stalled
    rb = rx_q.size();
    rdy_mode = 0;
    bi.mode = 1'b1;
    bi.data_len = 8'd6;
    bi.fs = 1'b1;
    for (int n = 0; n < 100 && rx_q.size() - rb < 3; n++) tick();
    rdy_mode = 3;
    tick();
    tick();
    chk("mid_txdv", bi.uart_txdv, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_txdv", bi.uart_txdv, 0);
    chk("mid_rst_txd", bi.uart_txd, 0);
    chk("mid_rst_fd", bi.fd, 0);
    chk("mid_rst_err", bi.err, 0);
    bi.fs = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_pkt("post_rst", 1'b0, 5, 0);

    run_pkt("max_len", 1'b1, 255, 0);

    for (int k = 0; k < 10; k++)
      run_pkt($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 12)),
              int'($urandom_range(0, 2)));

    run_nck("nck0", 1'b0, 0);
    run_nck("nck3", 1'b1, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
